// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte/half/word load-store, one-slot response
// buffer and post-reset zero scrub of the whole array.
module data_memory_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int SCRUB_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wren,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int WORDS_W = ADDR_W - 2;
  localparam int DEPTH   = 1 << WORDS_W;

  typedef enum logic {SCRUB, RUN} state_t;
  localparam state_t RST_STATE = (SCRUB_EN != 0) ? SCRUB : RUN;

  state_t               state_q, state_d;
  logic [WORDS_W-1:0]   cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [31:0]          mem [DEPTH];

  logic                 accept;
  logic                 misalign;
  logic [WORDS_W-1:0]   word_idx;
  logic [31:0]          rd_word;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [31:0]          ld_data;
  logic [3:0]           wr_be;
  logic [31:0]          wr_data;

  assign o_req_ready = (state_q == RUN) && (!rsp_valid_q || i_rsp_ready) && i_reset;
  assign accept      = i_req_valid && o_req_ready;
  assign o_busy      = (state_q == SCRUB);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

  assign word_idx = i_req_addr[ADDR_W-1:2];
  // Asynchronous array read at acceptance: a store committed on the previous
  // edge is already visible, so back-to-back store/load never returns stale data.
  assign rd_word  = mem[word_idx];

  always_comb begin
    misalign = 1'b0;
    ld_data  = rd_word;
    wr_be    = 4'b0000;
    wr_data  = i_req_wdata;
    byte_v   = 8'(rd_word >> {i_req_addr[1:0], 3'b000});
    half_v   = i_req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (i_req_size)
      2'b00: begin
        ld_data = i_req_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        wr_be   = 4'b0001 << i_req_addr[1:0];
        wr_data = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        misalign = i_req_addr[0];
        ld_data  = i_req_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        wr_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{i_req_wdata[15:0]}};
      end
      2'b10: begin
        misalign = |i_req_addr[1:0];
        wr_be    = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      SCRUB: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: ;
      default: state_d = RUN;
    endcase
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = misalign;
      rsp_rdata_d = (misalign || i_req_wren) ? '0 : ld_data;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array has no reset; only the scrub pass or legal stores change it.
  always_ff @(posedge i_clk) begin
    if (i_reset && state_q == SCRUB) begin
      mem[cnt_q] <= '0;
    end else if (accept && i_req_wren && !misalign) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (ADDR_W=11, SCRUB_EN=1).
module tb_data_memory_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_wren = 1'b0;
  logic [10:0] i_req_addr = '0;
  logic [1:0]  i_req_size = 2'b10;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  data_memory_ctrl #(.ADDR_W(11), .SCRUB_EN(1)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_wren    (i_req_wren),
    .i_req_addr    (i_req_addr),
    .i_req_size    (i_req_size),
    .i_req_unsigned(i_req_unsigned),
    .i_req_wdata   (i_req_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_busy        (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic wren, input logic [10:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    i_req_valid    = 1'b1;
    i_req_wren     = wren;
    i_req_addr     = addr;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_wdata    = wdata;
  endtask

  // Called at a negedge; returns response sampled at the negedge after acceptance.
  task automatic xfer(input string tag, input logic wren, input logic [10:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    i_rsp_ready = 1'b1;
    set_req(wren, addr, size, uns, wdata);
    n = 0;
    while (!o_req_ready && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    check({tag, "_ready"}, {31'b0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    check({tag, "_valid"}, {31'b0, o_rsp_valid}, 32'd1);
    check({tag, "_rdata"}, o_rsp_rdata, exp_rdata);
    check({tag, "_err"},   {31'b0, o_rsp_err}, {31'b0, exp_err});
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (o_busy && n < 2000) begin
      n++;
      @(negedge i_clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge i_clk);
    check("rst_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rst_ready", {31'b0, o_req_ready}, 32'd0);
    check("rst_busy",  {31'b0, o_busy},      32'd1);
    check("rst_rdata", o_rsp_rdata,          32'd0);
    check("rst_err",   {31'b0, o_rsp_err},   32'd0);

    i_reset = 1'b1;
    count_busy(n);
    check("scrub_cycles", n, 512);
    check("run_ready", {31'b0, o_req_ready}, 32'd1);

    xfer("lw_7fc",  1'b0, 11'h7FC, 2'b10, 1'b0, '0, 32'h0000_0000, 1'b0);
    xfer("sw_100",  1'b1, 11'h100, 2'b10, 1'b0, 32'hAABB_CCDD, 32'h0, 1'b0);
    xfer("lb_101",  1'b0, 11'h101, 2'b00, 1'b0, '0, 32'hFFFF_FFCC, 1'b0);
    xfer("lbu_101", 1'b0, 11'h101, 2'b00, 1'b1, '0, 32'h0000_00CC, 1'b0);
    xfer("lh_102",  1'b0, 11'h102, 2'b01, 1'b0, '0, 32'hFFFF_AABB, 1'b0);
    xfer("lhu_102", 1'b0, 11'h102, 2'b01, 1'b1, '0, 32'h0000_AABB, 1'b0);
    xfer("lbu_100", 1'b0, 11'h100, 2'b00, 1'b1, '0, 32'h0000_00DD, 1'b0);
    xfer("lw_u_100",1'b0, 11'h100, 2'b10, 1'b1, '0, 32'hAABB_CCDD, 1'b0);

    xfer("sw_104",  1'b1, 11'h104, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
    xfer("sb_105",  1'b1, 11'h105, 2'b00, 1'b0, 32'hFFFF_FF5A, 32'h0, 1'b0);
    xfer("lw_104",  1'b0, 11'h104, 2'b10, 1'b0, '0, 32'h1234_5A78, 1'b0);
    xfer("sh_106",  1'b1, 11'h106, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0);
    xfer("lw_104b", 1'b0, 11'h104, 2'b10, 1'b0, '0, 32'hBEEF_5A78, 1'b0);

    xfer("sh_103",  1'b1, 11'h103, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0, 1'b1);
    xfer("lw_100c", 1'b0, 11'h100, 2'b10, 1'b0, '0, 32'hAABB_CCDD, 1'b0);
    xfer("sz11",    1'b0, 11'h100, 2'b11, 1'b0, '0, 32'h0, 1'b1);
    xfer("lw_102",  1'b0, 11'h102, 2'b10, 1'b0, '0, 32'h0, 1'b1);
    xfer("sw_101",  1'b1, 11'h101, 2'b10, 1'b0, 32'h1111_1111, 32'h0, 1'b1);
    xfer("lw_100d", 1'b0, 11'h100, 2'b10, 1'b0, '0, 32'hAABB_CCDD, 1'b0);

    // Back-to-back: store, then load of same word, then byte load, one per cycle.
    set_req(1'b1, 11'h200, 2'b10, 1'b0, 32'hCAFE_F00D);
    @(posedge i_clk);
    #1 set_req(1'b0, 11'h200, 2'b10, 1'b0, '0);
    @(negedge i_clk);
    check("b2b_st_valid", {31'b0, o_rsp_valid}, 32'd1);
    check("b2b_st_rdata", o_rsp_rdata, 32'h0);
    check("b2b_ready1",   {31'b0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1 set_req(1'b0, 11'h203, 2'b00, 1'b1, '0);
    @(negedge i_clk);
    check("b2b_ld_valid", {31'b0, o_rsp_valid}, 32'd1);
    check("b2b_ld_rdata", o_rsp_rdata, 32'hCAFE_F00D);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    check("b2b_lb_rdata", o_rsp_rdata, 32'h0000_00CA);
    @(posedge i_clk);
    @(negedge i_clk);
    check("b2b_drained", {31'b0, o_rsp_valid}, 32'd0);

    // Backpressure: response held, next request stalled.
    i_rsp_ready = 1'b0;
    set_req(1'b0, 11'h104, 2'b10, 1'b0, '0);
    @(posedge i_clk);
    #1 set_req(1'b0, 11'h100, 2'b10, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("bp_ready", {31'b0, o_req_ready}, 32'd0);
      check("bp_valid", {31'b0, o_rsp_valid}, 32'd1);
      check("bp_rdata", o_rsp_rdata, 32'hBEEF_5A78);
      check("bp_err",   {31'b0, o_rsp_err}, 32'd0);
    end
    i_rsp_ready = 1'b1;
    #1 check("bp_pass_ready", {31'b0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    check("bp_second_valid", {31'b0, o_rsp_valid}, 32'd1);
    check("bp_second_rdata", o_rsp_rdata, 32'hAABB_CCDD);
    @(posedge i_clk);
    @(negedge i_clk);
    check("bp_drained", {31'b0, o_rsp_valid}, 32'd0);

    // Reset with a pending response discards it.
    i_rsp_ready = 1'b0;
    set_req(1'b0, 11'h100, 2'b10, 1'b0, '0);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    check("pend_valid", {31'b0, o_rsp_valid}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("rst_pend_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rst_pend_rdata", o_rsp_rdata, 32'd0);
    check("rst_pend_busy",  {31'b0, o_busy}, 32'd1);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (200) @(posedge i_clk);
    #1 i_reset = 1'b0;
    #1;
    check("mid_scrub_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("mid_scrub_ready", {31'b0, o_req_ready}, 32'd0);
    check("mid_scrub_busy",  {31'b0, o_busy}, 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    count_busy(n);
    check("rescrub_cycles", n, 512);
    xfer("lw_100_scrubbed", 1'b0, 11'h100, 2'b10, 1'b0, '0, 32'h0, 1'b0);
    xfer("lw_200_scrubbed", 1'b0, 11'h200, 2'b10, 1'b0, '0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, byte-address width; the array SHALL hold 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter SCRUB_EN, default 1, enables zero-fill of the array after reset.
REQ-003 i_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_req_valid  in  1  request present.
REQ-006 o_req_ready  out  1  request accepted when valid&ready high at a rising edge.
REQ-007 i_req_wren  in  1  1 = store, 0 = load.
REQ-008 i_req_addr  in  ADDR_W  byte address.
REQ-009 i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 i_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 o_rsp_valid  out  1  response present.
REQ-013 i_rsp_ready  in  1  response consumed when valid&ready high at a rising edge.
REQ-014 o_rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 o_rsp_err  out  1  access error flag for this response.
REQ-016 o_busy  out  1  high while scrubbing.

Function
REQ-017 States SCRUB and RUN; reset release enters SCRUB if SCRUB_EN=1, else RUN.
REQ-018 SCRUB: word counter 0..2**(ADDR_W-2)-1, one zero word written per cycle, o_req_ready=0, o_busy=1; after writing the last word, go to RUN next cycle.
REQ-019 RUN: o_req_ready = ~o_rsp_valid | i_rsp_ready (one response slot, pass-through when drained the same cycle).
REQ-020 Every accepted request (load or store) SHALL produce exactly one response, o_rsp_valid rising the cycle after acceptance (1-cycle latency).
REQ-021 o_rsp_valid, o_rsp_rdata, o_rsp_err SHALL hold stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-022 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> o_rsp_err=1, o_rsp_rdata=0, array unmodified.
REQ-023 Store byte: lane addr[1:0] written with wdata[7:0]; half: lanes {addr[1],0}+1:{addr[1],0} written with wdata[15:0]; word: all four lanes; other lanes unchanged.
REQ-024 Load: selected byte/half extracted from word addr[ADDR_W-1:2], then extended per i_req_unsigned; word loads ignore i_req_unsigned.
REQ-025 Load following a store to the same word in the next accepted cycle SHALL return post-store data (no stale read).
REQ-026 i_req_valid while o_req_ready=0 SHALL have no effect; requester must hold the request.
REQ-027 Store response: o_rsp_err=0, o_rsp_rdata=0 for legal stores.

Reset
REQ-028 While i_reset=0: o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_req_ready=0, o_busy=SCRUB_EN, scrub counter=0.
REQ-029 Reset asserted mid-scrub or mid-response SHALL discard pending response and restart scrub from word 0 on release.
REQ-030 Array contents are not cleared by reset itself; only SCRUB zeroes them.

Verification
REQ-031 Reset release, ADDR_W=11 -> o_busy high exactly 512 cycles, then o_req_ready=1; load word 0x7FC returns 0x00000000.
REQ-032 Store word 0x100=0xAABBCCDD, then load byte 0x101 signed -> 0xFFFFFFCC; unsigned -> 0x000000CC; load half 0x102 signed -> 0xFFFFAABB.
REQ-033 Store byte 0x105=0x5A over word 0x12345678 at 0x104 -> load word 0x104 returns 0x12345A78.
REQ-034 Store half to 0x103 data 0xBEEF -> o_rsp_err=1, load word 0x100 unchanged; size=11 load -> err=1, rdata=0.
REQ-035 Hold i_rsp_ready=0 for 3 cycles after a load -> o_req_ready=0, response stable; back-to-back requests with i_rsp_ready=1 -> one response per cycle, in order.
REQ-036 Assert i_reset=0 mid-scrub at counter 200 -> o_rsp_valid=0 immediately; on release scrub restarts at 0 and runs full 512 cycles.
